// File: rtl/alu_pkg.sv
// Shared types and constants for the EX-stage ALU sequencer:
// ALUOP classes, instruction opcode patterns, ALU operation codes, FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        ALUOP_D    = 2'b00,
        ALUOP_B    = 2'b01,
        ALUOP_R    = 2'b10,
        ALUOP_RSVD = 2'b11
    } aluop_e;

    // Exact R-type opcodes
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_LSL = 11'b11010011011;
    localparam logic [10:0] OPC_LSR = 11'b11010011010;

    // Wildcard opcodes: value plus care-mask (mask bit 0 = don't care)
    localparam logic [10:0] OPC_B        = 11'b00010100000;
    localparam logic [10:0] OPC_B_MASK   = 11'b11111100000;
    localparam logic [10:0] OPC_CBZ      = 11'b10110100000;
    localparam logic [10:0] OPC_CBZ_MASK = 11'b11111111000;

    // 4-bit ALU operation encodings
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LSL   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PB_SR = 4'b0111;  // pass-B (ALUOP B) or LSR (ALUOP R)
    localparam logic [3:0] OP_ZERO  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } seq_state_e;

    // True when opcode matches a wildcard pattern
    function automatic logic opc_match(input logic [10:0] opc,
                                       input logic [10:0] pat,
                                       input logic [10:0] mask);
        return (opc & mask) == (pat & mask);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ALU control decode: (ALUOP, opcode) -> 4-bit operation and shift flag.
// Purely combinational; the shift flag is what steers the iterative path.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    output logic [3:0]  operation,
    output logic        is_shift
);

    // Map the op class and opcode onto an ALU operation
    always_comb begin
        operation = OP_ORR;
        is_shift  = 1'b0;
        case (aluop_e'(alu_op))
            ALUOP_D: operation = OP_ADD;
            ALUOP_B: operation = OP_PB_SR;
            ALUOP_R: begin
                if (opcode == OPC_ADD) begin
                    operation = OP_ADD;
                end else if (opcode == OPC_SUB) begin
                    operation = OP_SUB;
                end else if (opcode == OPC_AND) begin
                    operation = OP_AND;
                end else if (opcode == OPC_ORR) begin
                    operation = OP_ORR;
                end else if (opcode == OPC_LSL) begin
                    operation = OP_LSL;
                    is_shift  = 1'b1;
                end else if (opcode == OPC_LSR) begin
                    operation = OP_PB_SR;
                    is_shift  = 1'b1;
                end else if (opc_match(opcode, OPC_B, OPC_B_MASK)) begin
                    operation = OP_ZERO;
                end else begin
                    operation = OP_ORR;
                end
            end
            default: operation = OP_ORR;
        endcase
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// EX-stage sequencer: accepts one decoded op per handshake, executes
// single-cycle ops in one cycle and LSL/LSR one bit per cycle, then holds
// the result until EX/MEM takes it. Backpressures ID/EX while shifting
// or while a held result is not being taken.
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [10:0]        opcode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic [3:0]         operation,
    output logic               busy
);

    seq_state_e         state;
    logic [SHAMT_W-1:0] cnt;
    logic [DATA_W-1:0]  acc;
    logic               shift_left;

    logic [3:0]         dec_operation;
    logic               dec_shift;
    logic [DATA_W-1:0]  exec_value;
    logic [DATA_W-1:0]  acc_next;
    logic               accept;

    alu_op_decode u_decode (
        .alu_op    (alu_op),
        .opcode    (opcode),
        .operation (dec_operation),
        .is_shift  (dec_shift)
    );

    // Handshake and status derived from the registered state
    always_comb begin
        in_ready  = ~reset & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
        accept    = in_valid & in_ready & ~flush;
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    // Single-cycle result; a shift only lands here when shamt is zero (result = A)
    always_comb begin
        exec_value = '0;
        if (dec_shift) begin
            exec_value = op_a;
        end else begin
            case (dec_operation)
                OP_ADD:   exec_value = op_a + op_b;
                OP_SUB:   exec_value = op_a - op_b;
                OP_AND:   exec_value = op_a & op_b;
                OP_ORR:   exec_value = op_a | op_b;
                OP_PB_SR: exec_value = op_b;
                default:  exec_value = '0;
            endcase
        end
    end

    // One-bit step of the iterative shifter
    always_comb begin
        acc_next = shift_left ? (acc << 1) : (acc >> 1);
    end

    // Sequencer FSM with registered result, zero flag and operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            shift_left <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            operation  <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        operation <= dec_operation;
                        if (dec_shift && (shamt != '0)) begin
                            acc        <= op_a;
                            cnt        <= shamt;
                            shift_left <= (dec_operation == OP_LSL);
                            state      <= S_SHIFT;
                        end else begin
                            result <= exec_value;
                            zero   <= (exec_value == '0);
                            state  <= S_DONE;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
